adc_read_ad7476: RTL
====================

# adc_read_ad7476

Serial read controller for the AD7476-class 12-bit ADC on the lab ADC-DAC board: the receive-side companion of the AD5626 DAC write path. On a one-cycle `start` strobe it:
- drives CS low and runs 16 SCLK cycles at a divided rate;
- shifts in the ADC's 4 leading zeros plus 12 data bits, MSB first;
- restores the bus to idle and presents the sample with a one-cycle `valid` pulse.

It sits between the user logic that requests conversions and the ADC pins.

## Interface
- `DELAY_FACTOR`, default 10: clk cycles per SCLK half-period and per setup/quiet phase. Legal range is 4..65535.
- `clk`  in  1: system clock. All logic is on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: conversion request strobe. It may be only one cycle wide.
- `busy`  out  1: high from acceptance of `start` until the result is delivered.
- `data`  out  12: last conversion result, unsigned. Held until the next result.
- `valid`  out  1: one-cycle pulse when `data` updates.
- `zero_err`  out  1: updated together with `valid`. High if any of the 4 leading bits read as 1.
- `cs`  out  1: ADC chip select, active LO.
- `sclk`  out  1: serial clock, idles HI.
- `sdata`  in  1: ADC serial data, asynchronous to `clk`.

## Operation
- `sdata` passes through a 2-flop synchronizer before use.
- Phase counter, 16 bits: counts 0..DELAY_FACTOR-1 within each non-IDLE state. The state advances on terminal count, and the counter clears on every state change.
- Bit counter, 4 bits, 15 down to 0. Shift register, 16 bits.
- FSM states:
  - IDLE: cs=1, sclk=1, busy=0. `start`=1 is sampled every clk, not gated by the phase counter. When it is seen: go to CS_SETUP, busy=1, bit counter=15.
  - CS_SETUP: cs=0, sclk=1 for DELAY_FACTOR cycles, then go to SCLK_LO.
  - SCLK_LO: sclk=0 for DELAY_FACTOR cycles. On its final cycle, shift the synchronized sdata in at the LSB: shreg <= {shreg[14:0], sdata_s}. Then go to SCLK_HI.
  - SCLK_HI: sclk=1 for DELAY_FACTOR cycles. If the bit counter is nonzero, decrement it and go to SCLK_LO; otherwise go to CS_HI.
  - CS_HI: cs=1, sclk=1 for DELAY_FACTOR cycles (ADC quiet time). On exit, in one edge:
    - data <= shreg[11:0];
    - zero_err <= |shreg[15:12];
    - valid <= 1 for one cycle;
    - busy <= 0;
    - state <= IDLE.
- `start` while busy=1 is ignored and not queued.
- `start` in the same cycle that `valid` is high is accepted, since busy=0 there.
- Each accepted `start` produces exactly one `valid`.

## Timing
- Reset values: cs=1, sclk=1, busy=0, valid=0, data=0, zero_err=0, state IDLE, counters 0, shreg 0.
- Reset mid-transfer: on the next edge all outputs return to reset values, no `valid` is produced, and the partial shreg is discarded.
- With `start` high in cycle 0:
  - cycle 1: cs=0, busy=1;
  - first sclk fall at cycle 1+D;
  - 16 falling edges, spaced 2D apart;
  - last sclk rise at cycle 1+32D;
  - cs rises at cycle 1+33D;
  - valid=1, busy=0 at cycle 1+34D.
  - With D=10: valid appears at cycle 341.
- Sampling occurs D-1 clk after the SCLK fall that launched the bit. The synchronizer adds 2 cycles, hence the D≥4 limit.
- `data` is stable except on the valid edge.

## Structure
- Shared include/package:
  - FSM state encodings: IDLE=0, CS_SETUP=1, SCLK_LO=2, SCLK_HI=3, CS_HI=4, in a 3-bit state register;
  - the constant 16 for frame length;
  - the constant 4 for leading-zero count.
- One natural sub-module: `sync_2ff`, a single-bit 2-flop synchronizer. It is reusable by other board inputs.
- FSM, counters and shift register stay in this module.

## Test plan
- Reset, then idle: cs=1, sclk=1, busy=0, valid=0, data=0 held for 1000 cycles with start=0.
- ADC model returns 0x0A5C (frame 0000_1010_0101_1100), D=10, one-cycle start:
  - exactly 16 sclk falls;
  - cs low for 33D cycles;
  - valid pulse at cycle 341 with data=0xA5C, zero_err=0.
- Frame 0x8FFF (leading bit set): valid with data=0xFFF and zero_err=1.
- start re-pulsed at cycles 50 and 200 of a transfer: ignored. Only one valid; the sclk count stays 16.
- start held high continuously, D=4: back-to-back frames with alternating values 0x000/0xFFF. Each valid carries the correct value; a new cs fall occurs the cycle after each valid.
- rst asserted at cycle 150 of a transfer: next edge gives cs=1, sclk=1, busy=0, and no valid is emitted. A following start completes normally with the correct data.

Source files
------------

// File: rtl/adc_read_ad7476_pkg.sv
// Shared definitions for the AD7476 serial read controller.
//   - FSM state encoding (3-bit state register)
//   - frame geometry: 16-bit frame = 4 leading zeros + 12 data bits
package adc_read_ad7476_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SCLK_LO  = 3'd2,
      ST_SCLK_HI  = 3'd3,
      ST_CS_HI    = 3'd4
   } state_e;

   localparam int FRAME_LEN  = 16;
   localparam int LEAD_ZEROS = 4;
   localparam int DATA_W     = FRAME_LEN - LEAD_ZEROS;
   localparam int PHASE_W    = 16;

   // A frame is good when every leading bit read back as zero.
   function automatic logic lead_err(input logic [FRAME_LEN-1:0] frame);
      return |frame[FRAME_LEN-1 -: LEAD_ZEROS];
   endfunction

endpackage

// File: rtl/adc_read_ad7476_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous board inputs.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (clears both stages)
//   d_i    asynchronous input
//   q_o    synchronized output, two clk cycles of latency
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/adc_read_ad7476.sv
// Serial read controller for an AD7476-class 12-bit ADC.
// A one-cycle start strobe runs one 16-bit frame: CS low, 16 SCLK periods at
// DELAY_FACTOR clk cycles per half-period, MSB-first capture, quiet time, then
// the 12-bit sample is presented with a one-cycle valid pulse.
// Ports:
//   clk       system clock, posedge
//   rst       synchronous active-high reset
//   start     conversion request strobe (ignored while busy)
//   busy      high from accepted start until the result is delivered
//   data      last conversion result, held until the next one
//   valid     one-cycle pulse when data updates
//   zero_err  any of the 4 leading bits read as 1 (updates with valid)
//   cs        ADC chip select, active low
//   sclk      ADC serial clock, idles high
//   sdata     ADC serial data, asynchronous to clk
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | bus idle, waiting for start
// ST_CS_SETUP | cs low, sclk high, setup before first fall
// ST_SCLK_LO  | sclk low; bit captured on the final cycle
// ST_SCLK_HI  | sclk high; loop back until all 16 bits are taken
// ST_CS_HI    | cs high quiet time; result delivered on exit
module adc_read_ad7476
   import adc_read_ad7476_pkg::*;
#(
   parameter int unsigned DELAY_FACTOR = 10   // legal 4..65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              zero_err,
   output logic              cs,
   output logic              sclk,
   input  logic              sdata
);

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DELAY_FACTOR - 1);
   localparam logic [3:0]         BIT_FIRST  = 4'(FRAME_LEN - 1);

   state_e                 state_q, state_d;
   logic [PHASE_W-1:0]     phase_q, phase_d;
   logic [3:0]             bit_q, bit_d;
   logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   zerr_q, zerr_d;
   logic                   valid_q, valid_d;
   logic                   cs_q, cs_d;
   logic                   sclk_q, sclk_d;
   logic                   busy_q, busy_d;

   logic                   sdata_s;
   logic                   phase_tc;
   logic                   accept;
   logic                   capture;
   logic                   deliver;

   sync_2ff u_sync_sdata (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (sdata),
      .q_o   (sdata_s)
   );

   assign phase_tc = (phase_q == PHASE_LAST);
   assign accept   = (state_q == ST_IDLE) && start;
   assign capture  = (state_q == ST_SCLK_LO) && phase_tc;
   assign deliver  = (state_q == ST_CS_HI) && phase_tc;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CS_SETUP;
         end
         ST_CS_SETUP: begin
            if (phase_tc) state_d = ST_SCLK_LO;
         end
         ST_SCLK_LO: begin
            if (phase_tc) state_d = ST_SCLK_HI;
         end
         ST_SCLK_HI: begin
            if (phase_tc) state_d = (bit_q == 4'd0) ? ST_CS_HI : ST_SCLK_LO;
         end
         ST_CS_HI: begin
            if (phase_tc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode. Decoding the next state and registering it keeps cs and
   // sclk glitch-free at the pins while matching the state timing exactly.
   always_comb begin
      cs_d   = 1'b1;
      sclk_d = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         ST_IDLE:     busy_d = 1'b0;
         ST_CS_SETUP: cs_d   = 1'b0;
         ST_SCLK_LO: begin
            cs_d   = 1'b0;
            sclk_d = 1'b0;
         end
         ST_SCLK_HI:  cs_d   = 1'b0;
         ST_CS_HI:    cs_d   = 1'b1;
         default: begin
            cs_d   = 1'b1;
            sclk_d = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   // Phase counter clears on every state change and sits at zero in idle.
   always_comb begin
      if ((state_q == ST_IDLE) || (state_d != state_q)) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   always_comb begin
      bit_d = bit_q;
      if (accept) begin
         bit_d = BIT_FIRST;
      end else if ((state_q == ST_SCLK_HI) && phase_tc && (bit_q != 4'd0)) begin
         bit_d = bit_q - 1'b1;
      end
   end

   always_comb begin
      shreg_d = shreg_q;
      if (capture) begin
         shreg_d = {shreg_q[FRAME_LEN-2:0], sdata_s};
      end
   end

   always_comb begin
      data_d  = data_q;
      zerr_d  = zerr_q;
      valid_d = 1'b0;
      if (deliver) begin
         data_d  = shreg_q[DATA_W-1:0];
         zerr_d  = lead_err(shreg_q);
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         zerr_q  <= 1'b0;
         valid_q <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         zerr_q  <= zerr_d;
         valid_q <= valid_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         busy_q  <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign data     = data_q;
   assign valid    = valid_q;
   assign zero_err = zerr_q;
   assign cs       = cs_q;
   assign sclk     = sclk_q;

endmodule
